peripheral_esp_rx: RTL and testbench
====================================

# peripheral_esp_rx

UART receive peripheral for the ESP Wi-Fi module link: the return path complementing the ESP driver peripheral that commands the module. It deserialises 8N1 bytes from the module's TX pin, buffers them in a FIFO and exposes data and status to the processor through the same cs/rd/wr/addr register bus used by the other peripherals. It also raises an interrupt line while bytes are pending.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz (20 ns period).
- BAUD, 115200: UART bit rate. DIV = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- FIFO_DEPTH, 16: receive FIFO entries; power of two, 2..128.

- clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- cs  in  1  chip select.
- rd  in  1  read strobe, qualified by cs.
- wr  in  1  write strobe, qualified by cs.
- addr  in  4  register address.
- d_in  in  16  write data.
- d_out  out  16  read data, registered.
- uart_rx  in  1  serial input from ESP TX, asynchronous, idle high.
- rx_irq  out  1  high while FIFO is not empty.

## Operation
- Registers: 0x0 RXDATA (read: {8'h00, byte}, pops FIFO); 0x2 STATUS (read: [7:0] count, [8] empty, [9] full, [10] overrun, [11] frame_err, [15:12] 0); 0x4 CTRL (write: d_in[0]=1 clears overrun, d_in[1]=1 clears frame_err, d_in[2]=1 flushes FIFO). Other addresses: read 0x0000, writes ignored.
- uart_rx passes a 2-flop synchroniser; the FSM uses only the synchronised value.
- FSM: IDLE -> START on synchronised high-to-low; bit counter loaded with DIV/2. START: at counter expiry resample; low -> DATA (counter reloaded DIV, bit index 0); high -> IDLE (glitch, nothing recorded). DATA: sample every DIV cycles, LSB first, shift into byte; after 8th sample -> STOP. STOP: sample after DIV cycles; high -> push byte, low -> set frame_err, discard byte; both -> IDLE. Frame error with line held low: IDLE waits for line high before next start detection.
- Push when full: byte dropped, overrun set, FIFO contents unchanged.
- Pop: one pop per read access, on the first cycle cs&rd&addr==0x0 is high (edge-detected; holding rd does not pop again). Empty read returns 0x0000, no pop, no flag.
- Simultaneous push and pop in the same cycle: both take effect, count unchanged; allowed even when full (pop frees the slot).
- Flush in the same cycle as a push: flush wins, FIFO empty.
- Sticky flags only clear via CTRL or reset; set and clear in the same cycle: set wins.
- rx_irq = ~empty, registered from FIFO state.
- Reset (any time, including mid-frame): FSM IDLE, partial byte discarded, FIFO empty, count 0, overrun 0, frame_err 0, d_out 0x0000, rx_irq 0, synchroniser flops 1.

## Timing
- d_out valid the cycle after the cs&rd sample; value held until next read access.
- Pointer/count update on the same edge as the pop; a STATUS read one cycle later reflects it.
- Byte push occurs at the STOP sample: 2 (sync) + DIV/2 + 9*DIV cycles after the falling edge on uart_rx; count, empty and rx_irq update on the following edge.
- Writes take effect on the edge where cs&wr is sampled; wr and rd both high: write performed, read ignored.
- Back-to-back frames with a single stop bit received without loss.

## Test plan
- Reset: hold sys_rst 5 cycles -> d_out 0x0000, rx_irq 0, STATUS read 0x0100.
- Send 0x41 at 115200 -> rx_irq 1, STATUS 0x0001; read 0x0 -> d_out 0x0041, then STATUS 0x0100, rx_irq 0.
- 3 µs low pulse on idle line -> no push, STATUS 0x0100; then 0xA5 received correctly.
- Frame 0x55 with stop bit low -> STATUS 0x0900; CTRL write 0x0002 -> STATUS 0x0100.
- Send 17 bytes 0x00..0x10 without reading -> STATUS 0x0610; reads return 0x0000..0x000F in order; 17th read 0x0000.
- Assert sys_rst during bit 4 of a frame -> no byte stored; next frame 0x3C received as 0x003C; pop issued on push cycle when full -> count stays 16.

Source files
------------

// File: rtl/peripheral_esp_rx.sv
// UART (8N1) receiver for the ESP module return link: synchroniser, receive FSM,
// byte FIFO and a cs/rd/wr/addr register window with a pending-data interrupt.
module peripheral_esp_rx #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV + 1);
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Edge detection costs one cycle behind the synchroniser, so the half-bit
  // load is shortened to land the start sample at 2 + DIV/2 after the edge.
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 2);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  localparam logic [3:0] ADDR_RXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rx_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          push_req;
  logic          ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          empty, full;
  logic          do_push, pop, flush;

  logic          overrun_q, overrun_d, ovr_set;
  logic          frame_err_q, frame_err_d;

  logic          rd_acc, rd_acc_q, rd_first, ctrl_wr;
  logic [15:0]   status;
  logic [15:0]   rdata;
  logic [15:0]   d_out_q;
  logic          irq_q;
  logic          unused_d_in;

  assign unused_d_in = ^d_in[15:3];

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      prev_q <= sync_q[1];
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Start detection is a synchronised falling edge, so after a frame error
  // with the line held low nothing restarts until the line returns high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s && prev_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          push_req = rx_s;
          ferr_set = ~rx_s;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_acc   = cs & rd & ~wr;
  assign rd_first = rd_acc & ~rd_acc_q;
  assign ctrl_wr  = cs & wr & (addr == ADDR_CTRL);
  assign flush    = ctrl_wr & d_in[2];

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);
  assign pop     = rd_first & (addr == ADDR_RXDATA) & ~empty;
  assign do_push = push_req & (~full | pop) & ~flush;
  assign ovr_set = push_req & full & ~pop & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (do_push && !pop) count_d = count_q + 1'b1;
      if (pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      irq_q   <= (count_d != '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign overrun_d   = (overrun_q & ~(ctrl_wr & d_in[0])) | ovr_set;
  assign frame_err_d = (frame_err_q & ~(ctrl_wr & d_in[1])) | ferr_set;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign status = {4'h0, frame_err_q, overrun_q, full, empty,
                   {(7 - AW){1'b0}}, count_q};

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_RXDATA: if (!empty) rdata = {8'h00, mem_q[rd_ptr_q]};
      ADDR_STATUS: rdata = status;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_acc_q <= 1'b0;
      d_out_q  <= '0;
    end else begin
      rd_acc_q <= rd_acc;
      if (rd_first) d_out_q <= rdata;
    end
  end

  assign d_out  = d_out_q;
  assign rx_irq = irq_q;

endmodule

// File: tb/tb_peripheral_esp_rx.sv
// Directed bench for peripheral_esp_rx, run at a fast bit rate (DIV = 32).
module tb_peripheral_esp_rx;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 1_562_500;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out;
  logic        uart_rx = 1'b1;
  logic        rx_irq;

  int unsigned tests = 0;
  int unsigned fails = 0;

  peripheral_esp_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(16)
  ) dut (
    .clk    (clk),
    .sys_rst(sys_rst),
    .cs     (cs),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .d_in   (d_in),
    .d_out  (d_out),
    .uart_rx(uart_rx),
    .rx_irq (rx_irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [15:0] data);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    data = d_out;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [15:0] data);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  logic [15:0] v;
  logic [15:0] popped;

  initial begin
    repeat (5) @(negedge clk);
    sys_rst = 1'b0;
    check("reset_dout", d_out, 16'h0000);
    check("reset_irq", {15'd0, rx_irq}, 16'h0000);
    reg_read(4'h2, v);
    check("reset_status", v, 16'h0100);

    send_byte(8'h41, 1'b1);
    repeat (2) @(negedge clk);
    check("one_irq", {15'd0, rx_irq}, 16'h0001);
    reg_read(4'h2, v);
    check("one_status", v, 16'h0001);
    reg_read(4'h0, v);
    check("one_data", v, 16'h0041);
    reg_read(4'h2, v);
    check("one_status_after", v, 16'h0100);
    check("one_irq_after", {15'd0, rx_irq}, 16'h0000);

    uart_rx = 1'b0;
    repeat (6) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    reg_read(4'h2, v);
    check("glitch_status", v, 16'h0100);
    @(negedge clk);
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    reg_read(4'h0, v);
    check("after_glitch_data", v, 16'h00A5);

    send_byte(8'h55, 1'b0);
    repeat (DIV) @(negedge clk);
    reg_read(4'h2, v);
    check("frame_err_status", v, 16'h0900);
    reg_write(4'h4, 16'h0002);
    reg_read(4'h2, v);
    check("frame_err_clear", v, 16'h0100);

    @(negedge clk);
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    repeat (2) @(negedge clk);
    reg_read(4'h2, v);
    check("overrun_status", v, 16'h0610);
    for (int i = 0; i < 16; i++) begin
      reg_read(4'h0, v);
      check($sformatf("fifo_order_%0d", i), v, 16'(i));
    end
    reg_read(4'h0, v);
    check("empty_read", v, 16'h0000);
    reg_read(4'h2, v);
    check("empty_overrun_status", v, 16'h0500);
    reg_write(4'h4, 16'h0001);
    reg_read(4'h2, v);
    check("overrun_clear", v, 16'h0100);

    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    check("midframe_reset_dout", d_out, 16'h0000);
    repeat (12 * DIV) @(negedge clk);
    reg_read(4'h2, v);
    check("midframe_reset_status", v, 16'h0100);
    check("midframe_reset_irq", {15'd0, rx_irq}, 16'h0000);
    @(negedge clk);
    send_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    reg_read(4'h0, v);
    check("after_reset_data", v, 16'h003C);

    @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    reg_read(4'h2, v);
    check("full_status", v, 16'h0210);
    // A pop sampled on the same edge as the 17th byte's stop sample
    // (2 + DIV/2 + 9*DIV cycles after its falling edge).
    fork
      send_byte(8'hEE, 1'b1);
      begin
        repeat (2 + DIV / 2 + 9 * DIV - 1) @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 4'h0;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        popped = d_out;
      end
    join
    check("push_pop_data", popped, 16'h0080);
    repeat (2) @(negedge clk);
    reg_read(4'h2, v);
    check("push_pop_status", v, 16'h0210);
    for (int i = 0; i < 16; i++) begin
      reg_read(4'h0, v);
      check($sformatf("push_pop_order_%0d", i), v, (i == 15) ? 16'h00EE : 16'h0081 + 16'(i));
    end

    @(negedge clk);
    send_byte(8'h12, 1'b1);
    repeat (2) @(negedge clk);
    reg_write(4'h4, 16'h0004);
    reg_read(4'h2, v);
    check("flush_status", v, 16'h0100);
    check("flush_irq", {15'd0, rx_irq}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
